// File: rtl/d3s_sample_readout.sv
// Timestamped phase-sample capture with a prescaled tick, a sample FIFO
// and a Wishbone classic register interface.
module d3s_sample_readout #(
  parameter int g_fifo_depth = 16
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        tm_time_valid_i,
  input  logic [27:0] tm_cycles_i,
  input  logic [15:0] sample_i,
  output logic        irq_o
);

  localparam int AW = $clog2(g_fifo_depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(g_fifo_depth);

  logic          en;
  logic [7:0]    presc;
  logic [7:0]    presc_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          ovf;
  logic [43:0]   mem [g_fifo_depth];

  logic          req;
  logic          tick;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          push_ok;
  logic          ovf_set;
  logic          ovf_clr;
  logic          cr_wr;
  logic [31:0]   rd_mux;
  logic          unused_dat;

  assign unused_dat = ^{wb_dat_i[31:17], wb_dat_i[15:9]};

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    tick    = en & (presc_cnt == presc);
    pop     = req & ~wb_we_i & (wb_adr_i == 2'd3) & ~empty;
    push    = tick & tm_time_valid_i;
    push_ok = push & (~full | pop);
    ovf_set = push & full & ~pop;
    ovf_clr = req & wb_we_i & (wb_adr_i == 2'd1) & wb_dat_i[16];
    cr_wr   = req & wb_we_i & (wb_adr_i == 2'd0);
    case (wb_adr_i)
      2'd0:    rd_mux = {23'd0, presc, en};
      2'd1:    rd_mux = {15'd0, ovf, 7'd0, 9'(count)};
      2'd2:    rd_mux = empty ? 32'd0 : {4'd0, mem[rd_ptr][43:16]};
      default: rd_mux = empty ? 32'd0 : {16'd0, mem[rd_ptr][15:0]};
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= {tm_cycles_i, sample_i};
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      en        <= 1'b0;
      presc     <= 8'd0;
      presc_cnt <= 8'd0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      ovf       <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 32'd0;
      irq_o     <= 1'b0;
    end else begin
      wb_ack_o <= req;
      if (req) begin
        wb_dat_o <= rd_mux;
      end
      if (cr_wr) begin
        en    <= wb_dat_i[0];
        presc <= wb_dat_i[8:1];
      end
      if (!en || tick) begin
        presc_cnt <= 8'd0;
      end else begin
        presc_cnt <= presc_cnt + 8'd1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A clear racing a fresh overflow leaves the flag set.
      ovf   <= (ovf & ~ovf_clr) | ovf_set;
      irq_o <= ~empty;
    end
  end

endmodule

// File: tb/tb_d3s_sample_readout.sv
// Self-checking bench for d3s_sample_readout: register table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_d3s_sample_readout;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] wdat = 32'd0;
  logic [31:0] rdat;
  logic        ack;
  logic        tvalid = 1'b0;
  logic [27:0] tm_cycles = 28'd0;
  logic [15:0] sample = 16'd0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  d3s_sample_readout #(.g_fifo_depth(DEPTH)) dut (
    .clk_sys_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(wdat), .wb_dat_o(rdat), .wb_ack_o(ack),
    .tm_time_valid_i(tvalid), .tm_cycles_i(tm_cycles), .sample_i(sample),
    .irq_o(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, tick from the enable-relative phase.
  bit        m_en, m_ack, m_irq, m_ovf;
  bit [7:0]  m_presc, m_phase;
  bit [31:0] m_dat;
  logic [43:0] q[$];

  initial begin
    forever begin
      bit req, tick, pop, push, set_ovf;
      int sz;
      @(posedge clk);
      if (rst) begin
        m_en = 1'b0; m_presc = 8'd0; m_phase = 8'd0; m_ovf = 1'b0;
        m_ack = 1'b0; m_irq = 1'b0; m_dat = 32'd0;
        q.delete();
      end else begin
        sz   = q.size();
        req  = cyc && stb && !m_ack;
        tick = m_en && (m_phase == m_presc);
        pop  = req && !we && adr == 2'd3 && sz != 0;
        push = tick && tvalid;
        if (req) begin
          case (adr)
            2'd0:    m_dat = {23'd0, m_presc, m_en};
            2'd1:    m_dat = {15'd0, m_ovf, 7'd0, 9'(sz)};
            2'd2:    m_dat = (sz != 0) ? {4'd0, q[0][43:16]} : 32'd0;
            default: m_dat = (sz != 0) ? {16'd0, q[0][15:0]} : 32'd0;
          endcase
        end
        m_irq = (sz != 0);
        m_ack = req;
        if (pop) void'(q.pop_front());
        set_ovf = 1'b0;
        if (push) begin
          if (q.size() < DEPTH) q.push_back({tm_cycles, sample});
          else set_ovf = 1'b1;
        end
        if (req && we && adr == 2'd1 && wdat[16]) m_ovf = 1'b0;
        if (set_ovf) m_ovf = 1'b1;
        if (m_en) m_phase = (m_phase == m_presc) ? 8'd0 : m_phase + 8'd1;
        else m_phase = 8'd0;
        if (req && we && adr == 2'd0) {m_presc, m_en} = wdat[8:0];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("mon_ack", 32'(ack), 32'(m_ack));
        check("mon_irq", 32'(irq), 32'(m_irq));
        if (m_ack) check("mon_rdata", rdat, m_dat);
      end
    end
  end

  task automatic wb_access(input logic [1:0] a, input bit w, input logic [31:0] d,
                           input bit tv_pulse, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    if (tv_pulse) tvalid = 1'b1;
    @(posedge clk); #1;
    check("ack_high", 32'(ack), 32'd1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (tv_pulse) tvalid = 1'b0;
    @(posedge clk); #1;
    check("ack_single", 32'(ack), 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_access(a, 1'b1, d, 1'b0, r);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_access(a, 1'b0, 32'd0, 1'b0, r);
    check(name, r, exp);
  endtask

  task automatic do_reset();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  adr;
    bit          we;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] r;
    tbl[0]  = '{2'd0, 1'b0, 32'd0,          32'd0};
    tbl[1]  = '{2'd1, 1'b0, 32'd0,          32'd0};
    tbl[2]  = '{2'd2, 1'b0, 32'd0,          32'd0};
    tbl[3]  = '{2'd3, 1'b0, 32'd0,          32'd0};
    tbl[4]  = '{2'd0, 1'b1, 32'hFFFF_FFFE,  32'd0};
    tbl[5]  = '{2'd0, 1'b0, 32'd0,          32'h0000_01FE};
    tbl[6]  = '{2'd1, 1'b1, 32'hFFFF_FFFF,  32'd0};
    tbl[7]  = '{2'd1, 1'b0, 32'd0,          32'd0};
    tbl[8]  = '{2'd2, 1'b1, 32'h1234_5678,  32'd0};
    tbl[9]  = '{2'd2, 1'b0, 32'd0,          32'd0};
    tbl[10] = '{2'd3, 1'b1, 32'h0000_FFFF,  32'd0};
    tbl[11] = '{2'd3, 1'b0, 32'd0,          32'd0};
    tbl[12] = '{2'd0, 1'b1, 32'h0000_002A,  32'd0};
    tbl[13] = '{2'd0, 1'b0, 32'd0,          32'h0000_002A};

    @(posedge clk); #1;
    do_reset();
    mon_en = 1'b1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);

    for (int i = 0; i < 14; i++) begin
      wb_access(tbl[i].adr, tbl[i].we, tbl[i].dat, 1'b0, r);
      if (!tbl[i].we) check($sformatf("tbl_%0d", i), r, tbl[i].exp);
    end

    // Strobe held high: acks must alternate, never back to back.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0;
    @(posedge clk); #1; check("hold_ack0", 32'(ack), 32'd1);
    @(posedge clk); #1; check("hold_ack1", 32'(ack), 32'd0);
    @(posedge clk); #1; check("hold_ack2", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1; check("hold_ack3", 32'(ack), 32'd0);

    // PRESC=20: one push every 21 cycles, ten after 210 cycles.
    do_reset();
    tvalid = 1'b1;
    wr(2'd0, 32'd41);
    repeat (209) @(posedge clk);
    #1;
    rd_chk("presc20_count", 2'd1, 32'd10);
    tvalid = 1'b0;

    // PRESC=0 fills and overflows; W1C clears OVF only.
    do_reset();
    tvalid = 1'b1;
    wr(2'd0, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    tvalid = 1'b0;
    wr(2'd0, 32'd0);
    rd_chk("ovf_full", 2'd1, 32'h0001_0010);
    check("irq_full", 32'(irq), 32'd1);
    wr(2'd1, 32'h0001_0000);
    rd_chk("ovf_clear", 2'd1, 32'h0000_0010);

    // Known samples: TS/DATA ordering, TS never pops.
    do_reset();
    wr(2'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tm_cycles = 28'(100 * i + 7);
      sample    = 16'(16'h1111 * (i + 1));
      tvalid    = 1'b1;
      @(posedge clk); #1;
      tvalid    = 1'b0;
    end
    wr(2'd0, 32'd0);
    rd_chk("known_cnt3", 2'd1, 32'd3);
    rd_chk("known_ts0", 2'd2, 32'd7);
    rd_chk("known_cnt_ts", 2'd1, 32'd3);
    rd_chk("known_data0", 2'd3, 32'h0000_1111);
    rd_chk("known_cnt2", 2'd1, 32'd2);
    rd_chk("known_ts1", 2'd2, 32'd107);
    rd_chk("known_data1", 2'd3, 32'h0000_2222);

    // Empty DATA read.
    do_reset();
    rd_chk("empty_data", 2'd3, 32'd0);
    rd_chk("empty_sr", 2'd1, 32'd0);
    check("empty_irq", 32'(irq), 32'd0);

    // Full FIFO, pop coincides with a push: no overflow.
    do_reset();
    tvalid = 1'b1;
    wr(2'd0, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    tvalid = 1'b0;
    wr(2'd1, 32'h0001_0000);
    rd_chk("full_pre", 2'd1, 32'h0000_0010);
    tm_cycles = 28'h0ABCDEF;
    sample    = 16'h5A5A;
    wb_access(2'd3, 1'b0, 32'd0, 1'b1, r);
    wr(2'd0, 32'd0);
    rd_chk("full_pushpop", 2'd1, 32'h0000_0010);

    // Reset during a pending access with five entries stored.
    do_reset();
    wr(2'd0, 32'd1);
    tvalid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tvalid = 1'b0;
    wr(2'd0, 32'd3);
    rd_chk("pre_rst_cnt", 2'd1, 32'd5);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd3;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("midrst_ack2", 32'(ack), 32'd0);
    rd_chk("midrst_cr", 2'd0, 32'd0);
    rd_chk("midrst_sr", 2'd1, 32'd0);

    // Randomized traffic checked by the model monitor.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      int op;
      logic [31:0] d;
      tm_cycles = 28'($urandom);
      sample    = 16'($urandom);
      tvalid    = 1'($urandom_range(0, 1));
      op        = $urandom_range(0, 9);
      case (op)
        0: begin
          d = $urandom;
          d[8:1] = 8'($urandom_range(0, 3));
          wr(2'd0, d);
        end
        1: wr(2'd1, $urandom);
        2: wb_access(2'd2, 1'b0, 32'd0, 1'b0, r);
        3, 4, 5: wb_access(2'd3, 1'b0, 32'd0, 1'b0, r);
        6: wb_access(2'd1, 1'b0, 32'd0, 1'b0, r);
        7: wb_access(2'd0, 1'b0, 32'd0, 1'b0, r);
        default: begin
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1;
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d3s_sample_readout.md
D3S_SAMPLE_READOUT -- requirements
Module: d3s_sample_readout

Interface
REQ-001 SHALL have generic g_fifo_depth, default 16, meaning the sample FIFO depth in entries (power of 2, 4..256).
REQ-002 SHALL have port clk_sys_i, in, 1, system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst_i, in, 1, reset: synchronous, active-high.
REQ-004 SHALL have port wb_cyc_i / wb_stb_i / wb_we_i, in, 1 each, Wishbone classic slave cycle, strobe and write-enable.
REQ-005 SHALL have port wb_adr_i, in, 2, word address.
REQ-006 SHALL have port wb_dat_i, in, 32, write data.
REQ-007 SHALL have port wb_dat_o, out, 32, read data.
REQ-008 SHALL have port wb_ack_o, out, 1, access acknowledge.
REQ-009 SHALL have port tm_time_valid_i, in, 1, WR time valid.
REQ-010 SHALL have port tm_cycles_i, in, 28, WR cycle counter.
REQ-011 SHALL have port sample_i, in, 16, phase sample to capture.
REQ-012 SHALL have port irq_o, out, 1, FIFO-not-empty interrupt level.

Function
REQ-013 SHALL provide a register map: 0=CR (RW: bit0 EN, bits[8:1] PRESC); 1=SR (bits[8:0] COUNT, bit16 OVF sticky, write 1 to clear); 2=TS (RO: head entry cycles, zero-extended); 3=DATA (RO: head entry sample, zero-extended; read pops).
REQ-014 SHALL assert wb_ack_o for exactly one cycle, in the cycle after wb_cyc_i&wb_stb_i is seen with wb_ack_o low; wb_dat_o is valid in the ack cycle.
REQ-015 SHALL ignore wb_stb_i while wb_ack_o is high (no back-to-back acks; each access costs 2 cycles).
REQ-016 SHALL return 0 for the unused bits of every register; writes to SR bits other than 16, and writes to TS/DATA, SHALL have no effect.
REQ-017 SHALL run an 8-bit prescaler counter while EN=1: it counts 0..PRESC; at the cycle it equals PRESC a sample tick is generated and it returns to 0.
REQ-018 SHALL, with PRESC=0, generate a tick every cycle while EN=1.
REQ-019 SHALL hold the prescaler counter at 0 and generate no ticks while EN=0; clearing EN SHALL NOT flush the FIFO.
REQ-020 SHALL, on a tick with tm_time_valid_i=1, push {tm_cycles_i, sample_i} as sampled in that cycle; on a tick with tm_time_valid_i=0 nothing is pushed and OVF is unchanged.
REQ-021 SHALL, on a push attempt while the FIFO is full and no pop occurs in the same cycle, drop the entry and set OVF.
REQ-022 SHALL pop the head in the cycle the DATA read is acknowledged; a DATA read on an empty FIFO returns 0 and does not pop.
REQ-023 SHALL, on simultaneous push and pop, perform both: COUNT unchanged, no overflow even when full.
REQ-024 SHALL return 0 on TS reads when empty; a TS read never pops.
REQ-025 SHALL, when a W1C write to OVF coincides with a new overflow, leave OVF set.
REQ-026 SHALL wrap FIFO read/write pointers modulo g_fifo_depth; COUNT ranges 0..g_fifo_depth.
REQ-027 SHALL drive irq_o = (COUNT != 0), registered, one cycle after the COUNT change.

Reset
REQ-028 SHALL, while rst_i=1 at a clock edge, set CR=0, COUNT=0, OVF=0, prescaler=0, wb_ack_o=0, wb_dat_o=0, irq_o=0.
REQ-029 SHALL discard any in-progress access on reset: no ack is issued for a strobe pending when rst_i asserts.

Verification
REQ-030 Write CR=(20<<1)|1, tm_time_valid_i=1 -> one push every 21 cycles; after 210 cycles SR.COUNT=10.
REQ-031 PRESC=0, EN=1 for 20 cycles with no reads, depth 16 -> COUNT=16, OVF=1; write SR=0x10000 -> OVF=0, COUNT stays 16.
REQ-032 Fill with known samples 0x1111..; read TS then DATA -> TS equals captured tm_cycles, DATA=0x1111, COUNT decrements by 1; TS read alone leaves COUNT unchanged.
REQ-033 FIFO empty, read DATA -> wb_dat_o=0, COUNT=0, irq_o=0; single ack of one-cycle width.
REQ-034 FIFO full, DATA read ack coincides with tick -> COUNT stays 16, OVF stays 0.
REQ-035 Assert rst_i mid-access with 5 entries stored -> no ack, CR=0, COUNT=0, irq_o=0 on the next cycle.
